// File: rtl/positadd_prod_pair_feeder.sv
// Pairs serialized ES2 posit products from a circular FIFO into operands for the 4-stage product adder; flush drains and pads an odd leftover.
// Latency: the product completing a pair is issued (out_start high) in the cycle after the edge following its acceptance.
// Backpressure: in_ready = FIFO not full and state RUN; optional macro POSITADD_FEEDER_ZERO_SKIP_EN drops zero products on entry.
module positadd_prod_pair_feeder #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [67:0] in_data,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        flush,
    output logic [67:0] out_in1,
    output logic [67:0] out_in2,
    output logic        out_start,
    output logic        flush_done,
    output logic [15:0] pair_count
);

    localparam int W  = 68;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] TWO_C   = CW'(2);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);
    // Pad operand: an exact zero, so the adder passes the leftover through unchanged.
    localparam logic [W-1:0]  PAD_C   = {{(W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_count;
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [W-1:0]    r_mem [DEPTH];
    logic [W-1:0]    r_out_in1;
    logic [W-1:0]    r_out_in2;
    logic            r_out_start;
    logic            r_flush_done;
    logic [15:0]     r_pair_count;

    logic            w_in_ready;
    logic            w_push;
    logic            w_wr;
    logic            w_pop2;
    logic            w_pad;
    logic [1:0]      w_pop_n;
    logic [PW-1:0]   w_rd_ptr1;
    logic [PW-1:0]   w_rd_ptr2;
    logic [PW-1:0]   w_wr_ptr1;
    logic [CW-1:0]   w_cnt_nxt;

    function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
        if (p == LAST_C) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    assign w_in_ready = (r_count < DEPTH_C) && (r_state == ST_RUN);
    assign w_push     = in_valid && w_in_ready;

`ifdef POSITADD_FEEDER_ZERO_SKIP_EN
    // Zero products complete the handshake but never occupy a slot.
    assign w_wr = w_push && !in_data[0];
`else
    assign w_wr = w_push;
`endif

    assign w_pop2    = (r_state != ST_DONE) && (r_count >= TWO_C);
    assign w_pad     = (r_state == ST_DRAIN) && (r_count == ONE_C);
    assign w_pop_n   = w_pop2 ? 2'd2 : (w_pad ? 2'd1 : 2'd0);
    assign w_rd_ptr1 = f_inc(r_rd_ptr);
    assign w_rd_ptr2 = f_inc(w_rd_ptr1);
    assign w_wr_ptr1 = f_inc(r_wr_ptr);
    assign w_cnt_nxt = r_count + CW'(w_wr) - CW'(w_pop_n);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_count      <= '0;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_out_in1    <= '0;
            r_out_in2    <= '0;
            r_out_start  <= 1'b0;
            r_flush_done <= 1'b0;
            r_pair_count <= '0;
        end else begin
            r_out_start  <= 1'b0;
            r_flush_done <= 1'b0;
            r_count      <= w_cnt_nxt;

            if (w_wr) begin
                r_wr_ptr <= w_wr_ptr1;
            end

            if (w_pop2) begin
                r_out_in1    <= r_mem[r_rd_ptr];
                r_out_in2    <= r_mem[w_rd_ptr1];
                r_rd_ptr     <= w_rd_ptr2;
                r_out_start  <= 1'b1;
                r_pair_count <= r_pair_count + 16'd1;
            end else if (w_pad) begin
                r_out_in1    <= r_mem[r_rd_ptr];
                r_out_in2    <= PAD_C;
                r_rd_ptr     <= w_rd_ptr1;
                r_out_start  <= 1'b1;
                r_pair_count <= r_pair_count + 16'd1;
            end

            case (r_state)
                ST_RUN: begin
                    if (flush) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_count == '0) begin
                        r_state      <= ST_DONE;
                        r_flush_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_RUN;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign in_ready   = w_in_ready;
    assign out_in1    = r_out_in1;
    assign out_in2    = r_out_in2;
    assign out_start  = r_out_start;
    assign flush_done = r_flush_done;
    assign pair_count = r_pair_count;

endmodule

// File: tb/tb_positadd_prod_pair_feeder.sv
// Directed bench for positadd_prod_pair_feeder: expected pairs are queued as stimulus is driven and checked as out_start pulses.
module tb_positadd_prod_pair_feeder;

    logic        clk;
    logic        rst_n;
    logic [67:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [67:0] out_in1;
    logic [67:0] out_in2;
    logic        out_start;
    logic        flush_done;
    logic [15:0] pair_count;

    typedef struct packed {
        logic [67:0] a;
        logic [67:0] b;
    } pair_t;

    pair_t       exp_q [$];
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] n_pairs  = '0;

    localparam logic [67:0] PAD  = 68'h1;
    localparam logic [67:0] A    = 68'h0000_0000_0000_0000_4;
    localparam logic [67:0] B    = 68'h8_0000_0000_0000_0008;
    localparam logic [67:0] JUNK = 68'hD_EAD0_0000_BEEF_0000;
    localparam logic [67:0] Z1   = 68'h1_0000_0000_0000_0011;
    localparam logic [67:0] Z2   = 68'h2_0000_0000_0000_0021;

    positadd_prod_pair_feeder #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .flush      (flush),
        .out_in1    (out_in1),
        .out_in2    (out_in2),
        .out_start  (out_start),
        .flush_done (flush_done),
        .pair_count (pair_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [67:0] obs, input logic [67:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        flush    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    function automatic pair_t mk(input logic [67:0] a, input logic [67:0] b);
        pair_t p;
        p.a = a;
        p.b = b;
        return p;
    endfunction

    function automatic logic [67:0] prod(input int base, input int i);
        return 68'(base) + (68'(i) << 4);
    endfunction

    // Output monitor: every out_start must match the oldest queued pair.
    always @(negedge clk) begin
        if (!rst_n) begin
            n_pairs = '0;
        end else if (out_start) begin
            n_pairs = n_pairs + 16'd1;
            if (exp_q.size() == 0) begin
                chk("unexpected_start", {67'h0, out_start}, 68'h0);
            end else begin
                pair_t e;
                e = exp_q.pop_front();
                chk("out_in1", out_in1, e.a);
                chk("out_in2", out_in2, e.b);
                chk("pair_count_mon", {52'h0, pair_count}, {52'h0, n_pairs});
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        flush    = 1'b0;
        step();
        step();
        chk("rst_out_start", {67'h0, out_start}, 68'h0);
        chk("rst_flush_done", {67'h0, flush_done}, 68'h0);
        chk("rst_pair_count", {52'h0, pair_count}, 68'h0);
        chk("rst_out_in1", out_in1, 68'h0);
        chk("rst_out_in2", out_in2, 68'h0);
        rst_n = 1'b1;
        step();
        chk("rst_in_ready", {67'h0, in_ready}, 68'h1);

        // Basic pair: A then B, issued two edges after B is accepted.
        exp_q.push_back(mk(A, B));
        in_valid = 1'b1;
        in_data  = A;
        step();
        in_data = B;
        step();
        in_valid = 1'b0;
        chk("pair_not_early", {67'h0, out_start}, 68'h0);
        step();
        chk("pair_start", {67'h0, out_start}, 68'h1);
        chk("pair_in1", out_in1, A);
        chk("pair_in2", out_in2, B);
        chk("pair_cnt1", {52'h0, pair_count}, 68'h1);
        step();
        chk("pulse_one_cycle", {67'h0, out_start}, 68'h0);
        chk("hold_in1", out_in1, A);
        chk("hold_in2", out_in2, B);

        // Three products, flush coinciding with the third push, junk held during drain.
        do_reset();
        exp_q.push_back(mk(prod(32'h300, 0), prod(32'h300, 1)));
        exp_q.push_back(mk(prod(32'h300, 2), PAD));
        in_valid = 1'b1;
        in_data  = prod(32'h300, 0);
        step();
        in_data = prod(32'h300, 1);
        step();
        in_data = prod(32'h300, 2);
        flush   = 1'b1;
        step();
        flush   = 1'b0;
        in_data = JUNK;
        chk("drain_in_ready0", {67'h0, in_ready}, 68'h0);
        chk("drain_first_pair", {67'h0, out_start}, 68'h1);
        step();
        chk("drain_pad_start", {67'h0, out_start}, 68'h1);
        chk("drain_in_ready1", {67'h0, in_ready}, 68'h0);
        chk("drain_no_done", {67'h0, flush_done}, 68'h0);
        step();
        in_valid = 1'b0;
        chk("drain_done", {67'h0, flush_done}, 68'h1);
        chk("done_in_ready", {67'h0, in_ready}, 68'h0);
        step();
        chk("done_one_cycle", {67'h0, flush_done}, 68'h0);
        chk("run_in_ready", {67'h0, in_ready}, 68'h1);
        chk("drain_pair_count", {52'h0, pair_count}, 68'h2);

        // Streaming: valid held for 20 cycles, never backpressured.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1;
            in_data  = prod(32'h500, i);
            if (i % 2 == 1) begin
                exp_q.push_back(mk(prod(32'h500, i - 1), prod(32'h500, i)));
            end
            chk("stream_in_ready", {67'h0, in_ready}, 68'h1);
            step();
        end
        in_valid = 1'b0;
        step();
        step();
        step();
        chk("stream_pair_count", {52'h0, pair_count}, 68'd10);

        // Flush with an empty FIFO.
        do_reset();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("eflush_in_ready", {67'h0, in_ready}, 68'h0);
        chk("eflush_no_done", {67'h0, flush_done}, 68'h0);
        step();
        chk("eflush_done", {67'h0, flush_done}, 68'h1);
        step();
        chk("eflush_done_clr", {67'h0, flush_done}, 68'h0);
        chk("eflush_run", {67'h0, in_ready}, 68'h1);
        chk("eflush_pairs", {52'h0, pair_count}, 68'h0);

        // Reset during drain discards the leftover.
        do_reset();
        exp_q.push_back(mk(prod(32'h700, 0), prod(32'h700, 1)));
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = prod(32'h700, i);
            step();
        end
        in_valid = 1'b0;
        flush    = 1'b1;
        step();
        flush = 1'b0;
        chk("pre_rst_in1", out_in1, prod(32'h700, 0));
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in1", out_in1, 68'h0);
        chk("mid_rst_in2", out_in2, 68'h0);
        chk("mid_rst_start", {67'h0, out_start}, 68'h0);
        chk("mid_rst_pairs", {52'h0, pair_count}, 68'h0);
        chk("mid_rst_done", {67'h0, flush_done}, 68'h0);
        step();
        step();
        rst_n = 1'b1;
        repeat (4) step();
        chk("post_rst_pairs", {52'h0, pair_count}, 68'h0);
        chk("post_rst_done", {67'h0, flush_done}, 68'h0);

        // Zero-flagged products.
        do_reset();
`ifdef POSITADD_FEEDER_ZERO_SKIP_EN
        exp_q.push_back(mk(A, B));
`else
        exp_q.push_back(mk(Z1, A));
        exp_q.push_back(mk(Z2, B));
`endif
        in_valid = 1'b1;
        in_data  = Z1;
        step();
        in_data = A;
        step();
        in_data = Z2;
        step();
        in_data = B;
        step();
        in_valid = 1'b0;
        step();
        step();
        step();
`ifdef POSITADD_FEEDER_ZERO_SKIP_EN
        chk("zero_pair_count", {52'h0, pair_count}, 68'h1);
`else
        chk("zero_pair_count", {52'h0, pair_count}, 68'h2);
`endif

        chk("scoreboard_empty", 68'(exp_q.size()), 68'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
